boot_loader: RTL

Byte-stream program loader sitting directly upstream of the CPU's instruction-load port.
- Accepts a framed program image one byte at a time over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words and writes them into the CPU with one-cycle load pulses at incrementing word addresses.
- Holds the CPU in reset for the whole load and releases it only after a verified checksum.

---
 rtl/boot_loader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/boot_loader.sv
// Byte-stream program loader: parses a count/words/checksum frame, writes big-endian words to the CPU
// instruction port with 1-cycle load strobes, and releases CPU reset only after a good checksum.
module boot_loader #(
   parameter logic [31:0] BASE_ADDR     = 32'h0,
   parameter int          MAX_WORDS     = 1024,
   parameter int          RELEASE_DELAY = 4
) (
   input  logic        i_sclk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_byte_in,
   input  logic        i_byte_valid,
   output logic        o_byte_ready,
   output logic        o_cpu_reset,
   output logic        o_cpu_load,
   output logic [31:0] o_cpu_addr,
   output logic [31:0] o_cpu_instr,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CNT_HI,
      S_CNT_LO,
      S_WORD,
      S_WRITE,
      S_CHECK,
      S_RELEASE,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);
   localparam logic [15:0] DLY_LAST = 16'(RELEASE_DELAY - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_count;
   logic [15:0] r_index;
   logic [7:0]  r_csum;
   logic [1:0]  r_bcnt;
   logic [23:0] r_word;
   logic [31:0] r_addr;
   logic [31:0] r_instr;
   logic [15:0] r_dly;

   logic        w_ready;
   logic        w_load;
   logic        w_cpu_reset;
   logic        w_busy;
   logic        w_done;
   logic        w_error;
   logic        w_accept;
   logic        w_start_ok;
   logic [15:0] w_count_full;
   logic [15:0] w_index_nxt;

   assign w_accept     = i_byte_valid & w_ready;
   assign w_start_ok   = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERROR));
   assign w_count_full = {r_count[15:8], i_byte_in};
   assign w_index_nxt  = r_index + 16'd1;

   always_ff @(posedge i_sclk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_ready     = 1'b0;
      w_load      = 1'b0;
      w_cpu_reset = 1'b1;
      w_busy      = 1'b1;
      w_done      = 1'b0;
      w_error     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (i_start) w_next = S_CNT_HI;
         end
         S_CNT_HI: begin
            w_ready = 1'b1;
            if (w_accept) w_next = S_CNT_LO;
         end
         S_CNT_LO: begin
            w_ready = 1'b1;
            if (w_accept) begin
               if ({1'b0, w_count_full} > MAX_W) begin
                  w_next = S_ERROR;
               end else if (w_count_full == 16'd0) begin
                  w_next = S_CHECK;
               end else begin
                  w_next = S_WORD;
               end
            end
         end
         S_WORD: begin
            w_ready = 1'b1;
            if (w_accept && (r_bcnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_load = 1'b1;
            w_next = (w_index_nxt == r_count) ? S_CHECK : S_WORD;
         end
         S_CHECK: begin
            w_ready = 1'b1;
            if (w_accept) w_next = (i_byte_in == r_csum) ? S_RELEASE : S_ERROR;
         end
         S_RELEASE: begin
            if (r_dly == DLY_LAST) w_next = S_DONE;
         end
         S_DONE: begin
            w_cpu_reset = 1'b0;
            w_done      = 1'b1;
            w_busy      = 1'b0;
            if (i_start) w_next = S_CNT_HI;
         end
         S_ERROR: begin
            w_error = 1'b1;
            w_busy  = 1'b0;
            if (i_start) w_next = S_CNT_HI;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Datapath: count/index/checksum bookkeeping and the word assembly register.
   always_ff @(posedge i_sclk) begin
      if (!i_reset) begin
         r_count <= 16'd0;
         r_index <= 16'd0;
         r_csum  <= 8'd0;
         r_bcnt  <= 2'd0;
         r_word  <= 24'd0;
         r_addr  <= BASE_ADDR;
         r_instr <= 32'd0;
         r_dly   <= 16'd0;
      end else begin
         if (w_start_ok) begin
            r_count <= 16'd0;
            r_index <= 16'd0;
            r_csum  <= 8'd0;
            r_bcnt  <= 2'd0;
         end
         // The checksum byte itself is compared, never folded in.
         if (w_accept && (r_state != S_CHECK)) r_csum <= r_csum ^ i_byte_in;
         case (r_state)
            S_CNT_HI: begin
               if (w_accept) r_count[15:8] <= i_byte_in;
            end
            S_CNT_LO: begin
               if (w_accept) begin
                  r_count[7:0] <= i_byte_in;
                  r_bcnt       <= 2'd0;
               end
            end
            S_WORD: begin
               if (w_accept) begin
                  r_word <= {r_word[15:0], i_byte_in};
                  r_bcnt <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_addr  <= BASE_ADDR + {14'd0, r_index, 2'b00};
                     r_instr <= {r_word, i_byte_in};
                  end
               end
            end
            S_WRITE: begin
               r_index <= w_index_nxt;
               r_bcnt  <= 2'd0;
            end
            S_CHECK: begin
               r_dly <= 16'd0;
            end
            S_RELEASE: begin
               r_dly <= r_dly + 16'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_byte_ready = w_ready;
   assign o_cpu_reset  = w_cpu_reset;
   assign o_cpu_load   = w_load;
   assign o_cpu_addr   = r_addr;
   assign o_cpu_instr  = r_instr;
   assign o_busy       = w_busy;
   assign o_done       = w_done;
   assign o_error      = w_error;

endmodule
